sys_ctrl: RTL and testbench

- Command controller directly downstream of the UART receiver, in the REF_CLK domain.
- Consumes parallel bytes from the receiver and decodes the framed command protocol.
- Drives register-file write/read and ALU operations.
- Returns read data or ALU results as bytes to the UART transmitter path.
- Owns the ALU clock-gate enable.

---
 rtl/sys_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sys_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// Framed-command controller between the UART receiver and the register file / ALU.
// Decodes write, read and ALU commands and returns results over the TX byte path.
module sys_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int FUN_WIDTH     = 4
) (
  input  logic                     REF_CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RF_RD_DATA,
  input  logic                     RF_RD_DATA_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     TX_BUSY,
  output logic                     RF_WR_EN,
  output logic                     RF_RD_EN,
  output logic [ADDR_WIDTH-1:0]    RF_ADDR,
  output logic [DATA_WIDTH-1:0]    RF_WR_DATA,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OP_A, S_OP_B,
    S_ALU_FUN, S_ALU_WAIT, S_TX_LSB, S_TX_MSB
  } state_t;

  localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

  state_t                     state_q;
  logic [ALU_OUT_WIDTH-1:0]   hold_q;
  logic                       two_byte_q;
  logic                       tx_sent_q;
  logic                       rf_wr_en_q;
  logic                       rf_rd_en_q;
  logic [ADDR_WIDTH-1:0]      rf_addr_q;
  logic [DATA_WIDTH-1:0]      rf_wr_data_q;
  logic                       alu_en_q;
  logic [FUN_WIDTH-1:0]       alu_fun_q;
  logic                       clk_gate_en_q;
  logic [DATA_WIDTH-1:0]      tx_p_data_q;
  logic                       tx_d_vld_q;
  logic [DATA_WIDTH-1:0]      tx_byte_d;

  assign tx_byte_d = (state_q == S_TX_MSB) ? hold_q[ALU_OUT_WIDTH-1:DATA_WIDTH]
                                           : hold_q[DATA_WIDTH-1:0];

  always_ff @(posedge REF_CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      two_byte_q    <= 1'b0;
      tx_sent_q     <= 1'b0;
      rf_wr_en_q    <= 1'b0;
      rf_rd_en_q    <= 1'b0;
      rf_addr_q     <= '0;
      rf_wr_data_q  <= '0;
      alu_en_q      <= 1'b0;
      alu_fun_q     <= '0;
      clk_gate_en_q <= 1'b0;
      tx_p_data_q   <= '0;
      tx_d_vld_q    <= 1'b0;
    end else begin
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      alu_en_q   <= 1'b0;
      tx_d_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_WR) begin
              state_q <= S_WR_ADDR;
            end else if (RX_P_DATA == CMD_RD) begin
              state_q <= S_RD_ADDR;
            end else if (RX_P_DATA == CMD_ALU_OP) begin
              state_q <= S_OP_A;
            end else if (RX_P_DATA == CMD_ALU_NOP) begin
              state_q       <= S_ALU_FUN;
              clk_gate_en_q <= 1'b1;
            end
          end
        end
        S_WR_ADDR: begin
          if (RX_D_VLD) begin
            rf_addr_q <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_q   <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (RX_D_VLD) begin
            rf_wr_data_q <= RX_P_DATA;
            rf_wr_en_q   <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_RD_ADDR: begin
          if (RX_D_VLD) begin
            rf_addr_q  <= RX_P_DATA[ADDR_WIDTH-1:0];
            rf_rd_en_q <= 1'b1;
            state_q    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (RF_RD_DATA_VLD) begin
            hold_q[DATA_WIDTH-1:0] <= RF_RD_DATA;
            two_byte_q             <= 1'b0;
            state_q                <= S_TX_LSB;
          end
        end
        S_OP_A: begin
          if (RX_D_VLD) begin
            rf_addr_q    <= '0;
            rf_wr_data_q <= RX_P_DATA;
            rf_wr_en_q   <= 1'b1;
            state_q      <= S_OP_B;
          end
        end
        S_OP_B: begin
          if (RX_D_VLD) begin
            rf_addr_q     <= ADDR_WIDTH'(1);
            rf_wr_data_q  <= RX_P_DATA;
            rf_wr_en_q    <= 1'b1;
            clk_gate_en_q <= 1'b1;
            state_q       <= S_ALU_FUN;
          end
        end
        S_ALU_FUN: begin
          if (RX_D_VLD) begin
            alu_fun_q <= RX_P_DATA[FUN_WIDTH-1:0];
            alu_en_q  <= 1'b1;
            state_q   <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          if (ALU_OUT_VLD) begin
            hold_q        <= ALU_OUT;
            clk_gate_en_q <= 1'b0;
            two_byte_q    <= 1'b1;
            state_q       <= S_TX_LSB;
          end
        end
        S_TX_LSB, S_TX_MSB: begin
          // Issue once when the transmitter is free, then hold until it reports busy
          // so the byte is known to be taken before moving on.
          if (!tx_sent_q) begin
            if (!TX_BUSY) begin
              tx_p_data_q <= tx_byte_d;
              tx_d_vld_q  <= 1'b1;
              tx_sent_q   <= 1'b1;
            end
          end else if (TX_BUSY) begin
            tx_sent_q <= 1'b0;
            state_q   <= (state_q == S_TX_LSB && two_byte_q) ? S_TX_MSB : S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RF_WR_EN    = rf_wr_en_q;
  assign RF_RD_EN    = rf_rd_en_q;
  assign RF_ADDR     = rf_addr_q;
  assign RF_WR_DATA  = rf_wr_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign TX_P_DATA   = tx_p_data_q;
  assign TX_D_VLD    = tx_d_vld_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: register file, ALU and transmitter responders plus a
// command-level reference of the expected RF/ALU/TX traffic.
module tb_sys_ctrl;
  localparam int RD_LAT = 2;

  logic        REF_CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_DATA;
  logic        RX_D_VLD;
  logic [7:0]  RF_RD_DATA;
  logic        RF_RD_DATA_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        TX_BUSY;
  logic        RF_WR_EN, RF_RD_EN, ALU_EN, CLK_GATE_EN, TX_D_VLD;
  logic [3:0]  RF_ADDR, ALU_FUN;
  logic [7:0]  RF_WR_DATA, TX_P_DATA;

  sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_OUT_WIDTH(16), .FUN_WIDTH(4)) dut (
    .REF_CLK(REF_CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD), .ALU_OUT(ALU_OUT),
    .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
    .RF_ADDR(RF_ADDR), .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 REF_CLK = ~REF_CLK;

  int checks = 0, errors = 0, cyc_n = 0, gate_err = 0, busy_err = 0;
  int busy_cnt = 0, tx_busy_len = 2, rd_cnt = 0, alu_cnt = 0, alu_lat = 3;
  logic [3:0]  rd_addr;
  logic [15:0] alu_val;
  logic        gate_exp = 1'b0, junk_on = 1'b0, junk_resp = 1'b0;
  logic [7:0]  rf_mem [16];
  logic [7:0]  rf_ref [16];
  logic [3:0]  exp_addr = 4'h0;
  logic [11:0] wr_log[$], exp_wr[$];
  logic [3:0]  rd_log[$], exp_rd[$], alu_log[$], exp_alu[$];
  logic [7:0]  tx_log[$], exp_tx[$];
  int          tx_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then let the RF/ALU/TX models respond.
  task automatic cyc();
    @(negedge REF_CLK);
    cyc_n++;
    if (junk_on) begin RX_D_VLD = 1'b0; junk_on = 1'b0; end
    RF_RD_DATA_VLD = 1'b0;
    if (ALU_OUT_VLD) gate_exp = 1'b0;
    ALU_OUT_VLD = 1'b0;
    if (busy_cnt > 0) busy_cnt--;
    if (CLK_GATE_EN !== gate_exp) gate_err++;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        RF_RD_DATA = rf_mem[rd_addr]; RF_RD_DATA_VLD = 1'b1;
        if (junk_resp) begin RX_P_DATA = 8'hAA; RX_D_VLD = 1'b1; junk_on = 1'b1; end
      end
    end
    if (alu_cnt > 0) begin
      alu_cnt--;
      if (alu_cnt == 0) begin
        ALU_OUT = alu_val; ALU_OUT_VLD = 1'b1;
        if (junk_resp) begin RX_P_DATA = 8'hBB; RX_D_VLD = 1'b1; junk_on = 1'b1; end
      end
    end
    if (RF_WR_EN === 1'b1) begin wr_log.push_back({RF_ADDR, RF_WR_DATA}); rf_mem[RF_ADDR] = RF_WR_DATA; end
    if (RF_RD_EN === 1'b1) begin rd_log.push_back(RF_ADDR); rd_addr = RF_ADDR; rd_cnt = RD_LAT; end
    if (ALU_EN === 1'b1) begin alu_log.push_back(ALU_FUN); alu_cnt = alu_lat; end
    if (TX_D_VLD === 1'b1) begin
      tx_log.push_back(TX_P_DATA); tx_cyc.push_back(cyc_n);
      if (TX_BUSY) busy_err++;
      busy_cnt = tx_busy_len;
    end
    TX_BUSY = (busy_cnt > 0);
  endtask

  task automatic settle(input int n);
    repeat (n) cyc();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) cyc();
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    cyc();
    RX_D_VLD = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (tx_log.size() < exp_tx.size() && n < 2000) begin cyc(); n++; end
    chk({tag, ":timeout"}, 32'(tx_log.size() >= exp_tx.size()), 32'd1);
    settle(tx_busy_len + 4);
  endtask

  task automatic drain(input string tag);
    chk({tag, ":wr_n"}, 32'(wr_log.size()), 32'(exp_wr.size()));
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++)
      chk({tag, ":wr"}, 32'(wr_log[i]), 32'(exp_wr[i]));
    chk({tag, ":rd_n"}, 32'(rd_log.size()), 32'(exp_rd.size()));
    for (int i = 0; i < rd_log.size() && i < exp_rd.size(); i++)
      chk({tag, ":rd_addr"}, 32'(rd_log[i]), 32'(exp_rd[i]));
    chk({tag, ":alu_n"}, 32'(alu_log.size()), 32'(exp_alu.size()));
    for (int i = 0; i < alu_log.size() && i < exp_alu.size(); i++)
      chk({tag, ":alu_fun"}, 32'(alu_log[i]), 32'(exp_alu[i]));
    chk({tag, ":tx_n"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      chk({tag, ":tx_byte"}, 32'(tx_log[i]), 32'(exp_tx[i]));
    chk({tag, ":clk_gate"}, 32'(gate_err), 32'd0);
    chk({tag, ":tx_while_busy"}, 32'(busy_err), 32'd0);
    chk({tag, ":addr_hold"}, 32'(RF_ADDR), 32'(exp_addr));
    wr_log.delete(); exp_wr.delete(); rd_log.delete(); exp_rd.delete();
    alu_log.delete(); exp_alu.delete(); tx_log.delete(); exp_tx.delete(); tx_cyc.delete();
    gate_err = 0; busy_err = 0;
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, ":rf_wr_en"}, 32'(RF_WR_EN), 32'd0);
    chk({tag, ":rf_rd_en"}, 32'(RF_RD_EN), 32'd0);
    chk({tag, ":rf_addr"}, 32'(RF_ADDR), 32'd0);
    chk({tag, ":rf_wr_data"}, 32'(RF_WR_DATA), 32'd0);
    chk({tag, ":alu_en"}, 32'(ALU_EN), 32'd0);
    chk({tag, ":alu_fun"}, 32'(ALU_FUN), 32'd0);
    chk({tag, ":clk_gate_en"}, 32'(CLK_GATE_EN), 32'd0);
    chk({tag, ":tx_p_data"}, 32'(TX_P_DATA), 32'd0);
    chk({tag, ":tx_d_vld"}, 32'(TX_D_VLD), 32'd0);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA); gap(); send_byte(a); gap(); send_byte(d);
    exp_wr.push_back({a[3:0], d}); rf_ref[a[3:0]] = d; exp_addr = a[3:0];
    wait_done("wr");
  endtask

  task automatic cmd_read(input logic [7:0] a, input logic jd, input logic jr);
    send_byte(8'hBB); gap();
    junk_resp = jr;
    send_byte(a);
    exp_rd.push_back(a[3:0]); exp_tx.push_back(rf_ref[a[3:0]]); exp_addr = a[3:0];
    if (jd) send_byte(8'hCC);
    wait_done("rd");
    junk_resp = 1'b0;
  endtask

  task automatic cmd_alu(input logic ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] f, input logic [15:0] v, input int lat,
                         input logic jd, input logic jr);
    alu_val = v; alu_lat = lat; junk_resp = jr;
    if (ops) begin
      send_byte(8'hCC); gap(); send_byte(a); gap();
      gate_exp = 1'b1; send_byte(b); gap();
      exp_wr.push_back({4'h0, a}); exp_wr.push_back({4'h1, b});
      rf_ref[0] = a; rf_ref[1] = b; exp_addr = 4'h1;
    end else begin
      gate_exp = 1'b1; send_byte(8'hDD); gap();
    end
    send_byte(f);
    exp_alu.push_back(f[3:0]); exp_tx.push_back(v[7:0]); exp_tx.push_back(v[15:8]);
    if (jd) begin cyc(); send_byte(8'hAA); end
    wait_done("alu");
    junk_resp = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int op;
    for (int i = 0; i < 16; i++) begin rf_mem[i] = 8'h00; rf_ref[i] = 8'h00; end
    RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0; RF_RD_DATA = 8'h00;
    RF_RD_DATA_VLD = 1'b0; ALU_OUT = 16'h0000; ALU_OUT_VLD = 1'b0; TX_BUSY = 1'b0;
    settle(3);
    chk_outs_zero("reset");
    RST = 1'b1;
    settle(2);

    cmd_write(8'h05, 8'h3C);
    drain("write");

    busy_cnt = 10; TX_BUSY = 1'b1;
    cmd_read(8'h05, 1'b0, 1'b0);
    drain("read_busy");

    cmd_alu(1'b1, 8'h0A, 8'h14, 8'h00, 16'h001E, 4, 1'b0, 1'b0);
    drain("alu_ops");

    tx_busy_len = 100;
    cmd_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 3, 1'b0, 1'b0);
    chk("alu_nop:msb_after_busy",
        32'((tx_cyc.size() >= 2) && (tx_cyc[1] - tx_cyc[0] > 100)), 32'd1);
    drain("alu_nop");
    tx_busy_len = 2;

    send_byte(8'h55);
    settle(5);
    drain("illegal");

    cmd_alu(1'b1, 8'h21, 8'h43, 8'h07, 16'hBEEF, 20, 1'b1, 1'b0);
    cmd_write(8'h01, 8'h02);
    drain("drop_in_wait");

    cmd_read(8'h01, 1'b1, 1'b1);
    cmd_alu(1'b0, 8'h00, 8'h00, 8'h13, 16'hA55A, 2, 1'b0, 1'b1);
    drain("coincident");

    cmd_write(8'h1F, 8'h5A);
    cmd_read(8'hEF, 1'b0, 1'b0);
    drain("addr_trunc");

    send_byte(8'hAA); send_byte(8'h03);
    #3 RST = 1'b0;
    #1 chk_outs_zero("reset_mid");
    gate_exp = 1'b0; exp_addr = 4'h0;
    settle(2);
    RST = 1'b1;
    settle(2);
    send_byte(8'h77);
    settle(4);
    drain("reset_mid_nowrite");
    cmd_read(8'h03, 1'b0, 1'b0);
    drain("after_reset");

    for (int k = 0; k < 40; k++) begin
      op = $urandom_range(0, 4);
      tx_busy_len = $urandom_range(1, 4);
      case (op)
        0: cmd_write(8'($urandom), 8'($urandom));
        1: cmd_read(8'($urandom), 1'($urandom), 1'($urandom));
        2: cmd_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                   $urandom_range(1, 6), 1'($urandom), 1'($urandom));
        3: cmd_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                   $urandom_range(1, 6), 1'($urandom), 1'($urandom));
        default: begin
          b = 8'($urandom);
          while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
          send_byte(b);
          settle(4);
        end
      endcase
      drain("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
